lcd_pixel_sc_fifo: RTL and testbench

//  Parametrised single-clock Avalon-ST pixel FIFO, successor to the fixed 64-bit/128-deep LCD pixel FIFO.

---
 rtl/lcd_pixel_sc_fifo.sv | 156 +++++++++++++++
 tb/tb_lcd_pixel_sc_fifo.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pixel_sc_fifo.sv
// Single-clock Avalon-ST pixel FIFO with show-ahead output.
// Each entry packs {sop, eop, empty, data}. The memory array has no reset.
// Fill level and almost-full are reported from registers.
// Optional store-and-forward release is enabled by defining LCD_PIXEL_SC_FIFO_PKT_MODE_EN.
// When that macro is undefined, the FIFO runs cut-through.
module lcd_pixel_sc_fifo #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned EMPTY_WIDTH = 3,
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned ALMOST_FULL = 124
) (
  input  logic                     clock,
  input  logic                     reset,
  // Write side
  input  logic [DATA_WIDTH-1:0]    avalonst_sink_data,
  input  logic [EMPTY_WIDTH-1:0]   avalonst_sink_empty,
  input  logic                     avalonst_sink_startofpacket,
  input  logic                     avalonst_sink_endofpacket,
  input  logic                     avalonst_sink_valid,
  output logic                     avalonst_sink_ready,
  // Read side
  output logic [DATA_WIDTH-1:0]    avalonst_source_data,
  output logic [EMPTY_WIDTH-1:0]   avalonst_source_empty,
  output logic                     avalonst_source_startofpacket,
  output logic                     avalonst_source_endofpacket,
  output logic                     avalonst_source_valid,
  input  logic                     avalonst_source_ready,
  // Status
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     almost_full
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned CountW = AddrW + 1;
  localparam int unsigned EntryW = DATA_WIDTH + EMPTY_WIDTH + 2;

  localparam logic [CountW-1:0] DepthCount = CountW'(DEPTH);
  localparam logic [CountW-1:0] AfCount    = CountW'(ALMOST_FULL);

  // Field positions inside a stored entry
  localparam int unsigned SopBit   = EntryW - 1;
  localparam int unsigned EopBit   = EntryW - 2;
  localparam int unsigned EmptyLsb = DATA_WIDTH;

  logic [EntryW-1:0] mem [DEPTH];

  logic [AddrW-1:0]  wr_ptr_q;
  logic [AddrW-1:0]  rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic [CountW-1:0] count_d;
  logic              almost_full_q;

  logic              full;
  logic              not_empty;
  logic              wr_en;
  logic              rd_en;
  logic [EntryW-1:0] wr_entry;
  logic [EntryW-1:0] head;

  assign full      = (count_q == DepthCount);
  assign not_empty = (count_q != '0);

  // Ready is decoded only from the count register and the reset input.
  // That keeps it free of any combinational path from the source side.
  assign avalonst_sink_ready = !reset && !full;

  assign wr_en = avalonst_sink_valid && avalonst_sink_ready;
  assign rd_en = avalonst_source_valid && avalonst_source_ready;

  assign wr_entry = {avalonst_sink_startofpacket, avalonst_sink_endofpacket,
                     avalonst_sink_empty, avalonst_sink_data};

  // Show-ahead head: the output fields always present mem[rd_ptr].
  assign head = mem[rd_ptr_q];

  assign avalonst_source_data          = head[DATA_WIDTH-1:0];
  assign avalonst_source_empty         = head[EmptyLsb +: EMPTY_WIDTH];
  assign avalonst_source_endofpacket   = head[EopBit];
  assign avalonst_source_startofpacket = head[SopBit];

  assign fill_level  = count_q;
  assign almost_full = almost_full_q;

  // Storage write. There is no reset here, so stale entries are simply unreachable.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  // Next occupancy. When a write and a read happen in the same cycle, they cancel.
  always_comb begin
    count_d = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers, count and almost-full register. The pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q       <= count_d;
      almost_full_q <= (count_d >= AfCount);
    end
  end

`ifdef LCD_PIXEL_SC_FIFO_PKT_MODE_EN
  // Store-and-forward: count the complete packets held in the FIFO.
  logic [CountW-1:0] pkt_count_q;
  logic [CountW-1:0] pkt_count_d;
  logic              wr_eop;
  logic              rd_eop;

  assign wr_eop = wr_en && avalonst_sink_endofpacket;
  assign rd_eop = rd_en && head[EopBit];

  // Next packet count. An eop written and an eop read in the same cycle cancel.
  always_comb begin
    pkt_count_d = pkt_count_q;
    unique case ({wr_eop, rd_eop})
      2'b10:   pkt_count_d = pkt_count_q + 1'b1;
      2'b01:   pkt_count_d = pkt_count_q - 1'b1;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  // Packet count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  // The full override releases a packet too large to fit, so the FIFO cannot deadlock.
  assign avalonst_source_valid = not_empty && ((pkt_count_q != '0) || full);
`else
  // Cut-through: any stored beat is presented at the output.
  assign avalonst_source_valid = not_empty;
`endif

endmodule

// File: tb/tb_lcd_pixel_sc_fifo.sv
// Self-checking bench for lcd_pixel_sc_fifo using a queue-based reference model.
// The bench's own expectations follow LCD_PIXEL_SC_FIFO_PKT_MODE_EN in the same way as the design.
module tb_lcd_pixel_sc_fifo;

  localparam int DW    = 64;
  localparam int EW    = 3;
  localparam int DEPTH = 128;
  localparam int AF    = 124;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [DW-1:0] data;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          sink_valid;
  logic          sink_ready;
  logic          source_ready;
  logic          source_valid;
  logic [DW-1:0] source_data;
  logic [EW-1:0] source_empty;
  logic          source_sop;
  logic          source_eop;
  logic [7:0]    fill_level;
  logic          almost_full;
  beat_t         in_beat;

  int checks = 0;
  int errors = 0;

  beat_t q[$];

  always #5 clock = ~clock;

  lcd_pixel_sc_fifo #(
    .DATA_WIDTH (DW),
    .EMPTY_WIDTH(EW),
    .DEPTH      (DEPTH),
    .ALMOST_FULL(AF)
  ) dut (
    .clock                        (clock),
    .reset                        (reset),
    .avalonst_sink_data           (in_beat.data),
    .avalonst_sink_empty          (in_beat.empty),
    .avalonst_sink_startofpacket  (in_beat.sop),
    .avalonst_sink_endofpacket    (in_beat.eop),
    .avalonst_sink_valid          (sink_valid),
    .avalonst_sink_ready          (sink_ready),
    .avalonst_source_data         (source_data),
    .avalonst_source_empty        (source_empty),
    .avalonst_source_startofpacket(source_sop),
    .avalonst_source_endofpacket  (source_eop),
    .avalonst_source_valid        (source_valid),
    .avalonst_source_ready        (source_ready),
    .fill_level                   (fill_level),
    .almost_full                  (almost_full)
  );

  // Reference model: the FIFO contents are a queue of beats.
  function automatic bit m_ready();
    return !reset && (q.size() != DEPTH);
  endfunction

  function automatic bit m_valid();
    if (q.size() == 0) return 1'b0;
`ifdef LCD_PIXEL_SC_FIFO_PKT_MODE_EN
    if (q.size() == DEPTH) return 1'b1;
    foreach (q[i]) if (q[i].eop) return 1'b1;
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  // Advance one clock edge and update the model from the inputs as currently driven.
  task automatic tick();
    bit wr;
    bit rd;
    wr = sink_valid && m_ready();
    rd = source_ready && m_valid();
    @(posedge clock);
    if (reset) begin
      q.delete();
    end else begin
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(in_beat);
    end
    #1;
  endtask

  task automatic set_beat(input logic [DW-1:0] d, input logic sop, input logic eop);
    in_beat.data  = d;
    in_beat.sop   = sop;
    in_beat.eop   = eop;
    in_beat.empty = EW'($urandom);
  endtask

  task automatic reset_dut();
    reset        = 1'b1;
    sink_valid   = 1'b0;
    source_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    sink_valid   = 1'b0;
    source_ready = 1'b0;
    set_beat(64'h0, 1'b0, 1'b0);
    tick();
    #1;
    checks++;
    if (sink_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_low: got %b want 0", sink_ready);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (sink_ready !== 1'b1 || source_valid !== 1'b0 || fill_level !== 8'd0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b fill=%0d af=%b want 1 0 0 0",
               sink_ready, source_valid, fill_level, almost_full);
    end
    // Write three single-beat packets, with no reads.
    for (int k = 0; k < 3; k++) begin
      set_beat(64'hA + k, 1'b1, 1'b1);
      sink_valid = 1'b1;
      tick();
      checks++;
      if (source_valid !== 1'b1 || source_data !== 64'hA) begin
        errors++;
        $display("FAIL basic_head_%0d: got vld=%b data=%0h want 1 a", k, source_valid, source_data);
      end
    end
    sink_valid = 1'b0;
    #1;
    checks++;
    if (fill_level !== 8'd3) begin
      errors++; $display("FAIL basic_fill: got %0d want 3", fill_level);
    end
  endtask

  task automatic test_fill_and_hold();
    int i   = 0;
    int exp = 0;
    int cyc = 0;
    bit acc;
    bit del;
    reset_dut();
    while (i < DEPTH) begin
      set_beat(64'h1000 + i, i == 0, 1'b0);
      sink_valid = 1'b1;
      #1;
      checks++;
      if (almost_full !== (i >= AF)) begin
        errors++; $display("FAIL almost_full_at_%0d: got %b want %b", i, almost_full, i >= AF);
      end
      tick();
      i++;
    end
    set_beat(64'h1000 + i, 1'b0, 1'b0);
    for (int h = 0; h < 3; h++) begin
      tick();
      checks++;
      if (sink_ready !== 1'b0 || fill_level !== 8'd128 || almost_full !== 1'b1) begin
        errors++;
        $display("FAIL full_hold: got rdy=%b fill=%0d af=%b want 0 128 1",
                 sink_ready, fill_level, almost_full);
      end
    end
    // Drain the FIFO while the held beats 128 and 129 are pushed in.
    source_ready = 1'b1;
    while (exp < 130 && cyc < 1000) begin
      if (i < 130) set_beat(64'h1000 + i, 1'b0, i == 129);
      sink_valid = (i < 130);
      #1;
      acc = sink_valid && m_ready();
      del = m_valid();
      checks++;
      if (source_valid !== del) begin
        errors++; $display("FAIL drain_valid: got %b want %b", source_valid, del);
      end
      if (del) begin
        checks++;
        if (source_data !== 64'h1000 + exp) begin
          errors++; $display("FAIL drain_order: got %0h want %0h", source_data, 64'h1000 + exp);
        end
        exp++;
      end
      tick();
      if (acc) i++;
      cyc++;
    end
    checks++;
    if (exp != 130) begin
      errors++; $display("FAIL drain_count: got %0d want 130", exp);
    end
    sink_valid   = 1'b0;
    source_ready = 1'b0;
  endtask

  task automatic test_full_read_and_simul();
    reset_dut();
    sink_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_beat(64'h2000 + i, 1'b1, 1'b1);
      tick();
    end
    sink_valid   = 1'b0;
    source_ready = 1'b1;
    #1;
    checks++;
    if (sink_ready !== 1'b0 || fill_level !== 8'd128) begin
      errors++; $display("FAIL at_full: got rdy=%b fill=%0d want 0 128", sink_ready, fill_level);
    end
    tick();
    source_ready = 1'b0;
    #1;
    checks++;
    if (sink_ready !== 1'b1 || fill_level !== 8'd127) begin
      errors++; $display("FAIL full_minus_one: got rdy=%b fill=%0d want 1 127", sink_ready, fill_level);
    end
    // Simultaneous read and write at fill level 1
    reset_dut();
    set_beat(64'h55, 1'b1, 1'b1);
    sink_valid = 1'b1;
    tick();
    set_beat(64'h66, 1'b1, 1'b1);
    source_ready = 1'b1;
    #1;
    checks++;
    if (source_data !== 64'h55) begin
      errors++; $display("FAIL simul_head_before: got %0h want 55", source_data);
    end
    tick();
    sink_valid   = 1'b0;
    source_ready = 1'b0;
    #1;
    checks++;
    if (fill_level !== 8'd1 || source_data !== 64'h66 || source_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul_rw: got fill=%0d data=%0h vld=%b want 1 66 1",
               fill_level, source_data, source_valid);
    end
  endtask

  task automatic test_pkt_release();
    bit exp_v;
    reset_dut();
    for (int k = 1; k <= 4; k++) begin
      set_beat(64'h300 + k, k == 1, k == 4);
      sink_valid = 1'b1;
      tick();
`ifdef LCD_PIXEL_SC_FIFO_PKT_MODE_EN
      exp_v = (k == 4);
`else
      exp_v = 1'b1;
`endif
      checks++;
      if (source_valid !== exp_v) begin
        errors++; $display("FAIL pkt_release_beat%0d: got %b want %b", k, source_valid, exp_v);
      end
    end
    sink_valid = 1'b0;
  endtask

  task automatic test_oversize_pkt();
    int i   = 0;
    int exp = 0;
    int cyc = 0;
    bit acc;
    bit del;
    reset_dut();
    sink_valid = 1'b1;
    while (i < DEPTH) begin
      set_beat(64'h4000 + i, i == 0, 1'b0);
      tick();
      i++;
    end
    #1;
    checks++;
    if (source_valid !== 1'b1 || fill_level !== 8'd128) begin
      errors++; $display("FAIL oversize_full_valid: got vld=%b fill=%0d want 1 128", source_valid, fill_level);
    end
    while (exp < 130 && cyc < 2000) begin
      if (i < 130) set_beat(64'h4000 + i, 1'b0, i == 129);
      sink_valid   = (i < 130);
      source_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = sink_valid && m_ready();
      del = source_ready && m_valid();
      if (del) begin
        checks++;
        if (source_valid !== 1'b1 || source_data !== 64'h4000 + exp) begin
          errors++;
          $display("FAIL oversize_order: got vld=%b data=%0h want 1 %0h", source_valid, source_data,
                   64'h4000 + exp);
        end
        exp++;
      end
      tick();
      if (acc) i++;
      cyc++;
    end
    checks++;
    if (exp != 130) begin
      errors++; $display("FAIL oversize_deadlock: delivered %0d want 130", exp);
    end
    sink_valid   = 1'b0;
    source_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    sink_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_beat(64'h500 + i, i == 0, 1'b0);
      tick();
    end
    checks++;
    if (fill_level !== 8'd10) begin
      errors++; $display("FAIL mid_fill10: got %0d want 10", fill_level);
    end
    reset = 1'b1;
    set_beat(64'h5AA, 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (fill_level !== 8'd0 || source_valid !== 1'b0 || almost_full !== 1'b0 || sink_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_state: got fill=%0d vld=%b af=%b rdy=%b want 0 0 0 1",
               fill_level, source_valid, almost_full, sink_ready);
    end
    tick();
    sink_valid = 1'b0;
    #1;
    checks++;
    if (fill_level !== 8'd1 || source_valid !== 1'b1 || source_data !== 64'h5AA) begin
      errors++;
      $display("FAIL mid_after_write: got fill=%0d vld=%b data=%0h want 1 1 5aa",
               fill_level, source_valid, source_data);
    end
  endtask

  task automatic test_random();
    int pv = 50;
    int pr = 50;
    beat_t got;
    reset_dut();
    for (int c = 0; c < 5000; c++) begin
      if (c % 500 == 0) begin
        pv = $urandom_range(10, 95);
        pr = $urandom_range(10, 95);
      end
      reset        = ($urandom_range(0, 299) == 0);
      sink_valid   = ($urandom_range(0, 99) < pv);
      source_ready = ($urandom_range(0, 99) < pr);
      set_beat({$urandom, $urandom}, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      #1;
      checks++;
      if (sink_ready !== m_ready()) begin
        errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, sink_ready, m_ready());
      end
      checks++;
      if (source_valid !== m_valid()) begin
        errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, source_valid, m_valid());
      end
      checks++;
      if (fill_level !== 8'(q.size()) || almost_full !== (q.size() >= AF)) begin
        errors++;
        $display("FAIL rnd_level c%0d: got fill=%0d af=%b want %0d %b", c, fill_level, almost_full,
                 q.size(), q.size() >= AF);
      end
      if (m_valid()) begin
        got = {source_sop, source_eop, source_empty, source_data};
        checks++;
        if (got !== q[0]) begin
          errors++; $display("FAIL rnd_head c%0d: got %0h want %0h", c, got, q[0]);
        end
      end
      tick();
    end
    reset        = 1'b0;
    sink_valid   = 1'b0;
    source_ready = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    sink_valid   = 1'b0;
    source_ready = 1'b0;
    in_beat      = '0;
    test_reset();
    test_fill_and_hold();
    test_full_read_and_simul();
    test_pkt_release();
    test_oversize_pkt();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
